// File: rtl/vespa_prio_pkg.sv
// ============================================================================
// Module   : vespa_prio_pkg
// Purpose  : Shared state encoding, 2-bit typedefs and default cycle constants
//            for the priority stepdown driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vespa_prio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ARM    = 3'd2,
    ST_FIRE   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_REPORT = 3'd5
  } state_t;

  typedef logic [1:0] grant_t;
  typedef logic [1:0] skew_t;

  localparam int c_DEF_CLR_CYC     = 2;
  localparam int c_DEF_ARM_CYC     = 1;
  localparam int c_DEF_PULSE_CYC   = 2;
  localparam int c_DEF_TIMEOUT_CYC = 16;
  localparam int c_DEF_SYNC_STAGES = 2;

endpackage

`default_nettype wire

// File: rtl/vespa_sync_bus.sv
// ============================================================================
// Module   : vespa_sync_bus
// Purpose  : STAGES-deep flop chain bringing an asynchronous bus into clk.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vespa_sync_bus #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/vespa_priority_stepdown_driver.sv
// ============================================================================
// Module   : vespa_priority_stepdown_driver
// Purpose  : Clears, arms and fires the two-input priority latch stage, then
//            reports the synchronized {o1,o0} outcome on a valid/ready port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vespa_priority_stepdown_driver
  import vespa_prio_pkg::*;
#(
  parameter int CLR_CYC     = c_DEF_CLR_CYC,
  parameter int ARM_CYC     = c_DEF_ARM_CYC,
  parameter int PULSE_CYC   = c_DEF_PULSE_CYC,
  parameter int TIMEOUT_CYC = c_DEF_TIMEOUT_CYC,
  parameter int SYNC_STAGES = c_DEF_SYNC_STAGES
) (
  input  logic       CELCLK,
  input  logic       CELRST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_mask,
  input  logic [1:0] req_skew0,
  input  logic [1:0] req_skewX,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_grant,
  output logic       rsp_timeout,
  output logic       i0,
  output logic       i1,
  input  logic       o0,
  input  logic       o1,
  output logic       Tstate,
  output logic       Tpriority0_0,
  output logic       Tpriority0_1,
  output logic       TpriorityX_0,
  output logic       TpriorityX_1,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] c_CLR_LAST   = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] c_ARM_LAST   = CW'(ARM_CYC - 1);
  localparam logic [CW-1:0] c_PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] c_TO_LAST    = CW'(TIMEOUT_CYC - 1);

  state_t        r_state,   w_state_nxt;
  logic [CW-1:0] r_ph,      w_ph_nxt;
  logic [CW-1:0] r_to,      w_to_nxt;
  grant_t        r_mask,    w_mask_nxt;
  skew_t         r_skew0,   w_skew0_nxt;
  skew_t         r_skewx,   w_skewx_nxt;
  grant_t        r_grant,   w_grant_nxt;
  logic          r_tstate,  w_tstate_nxt;
  logic          r_i0,      w_i0_nxt;
  logic          r_i1,      w_i1_nxt;
  logic          r_valid,   w_valid_nxt;
  logic          r_timeout, w_timeout_nxt;
  grant_t        w_sync;

  vespa_sync_bus #(
    .WIDTH  (2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (CELCLK),
    .rst (CELRST),
    .i_d ({o1, o0}),
    .o_q (w_sync)
  );

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      r_state   <= ST_IDLE;
      r_ph      <= '0;
      r_to      <= '0;
      r_mask    <= '0;
      r_skew0   <= '0;
      r_skewx   <= '0;
      r_grant   <= '0;
      r_tstate  <= 1'b0;
      r_i0      <= 1'b0;
      r_i1      <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ph      <= w_ph_nxt;
      r_to      <= w_to_nxt;
      r_mask    <= w_mask_nxt;
      r_skew0   <= w_skew0_nxt;
      r_skewx   <= w_skewx_nxt;
      r_grant   <= w_grant_nxt;
      r_tstate  <= w_tstate_nxt;
      r_i0      <= w_i0_nxt;
      r_i1      <= w_i1_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ph_nxt      = r_ph;
    w_to_nxt      = r_to;
    w_mask_nxt    = r_mask;
    w_skew0_nxt   = r_skew0;
    w_skewx_nxt   = r_skewx;
    w_grant_nxt   = r_grant;
    w_tstate_nxt  = r_tstate;
    w_i0_nxt      = 1'b0;
    w_i1_nxt      = 1'b0;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = r_timeout;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_mask_nxt    = req_mask;
          w_skew0_nxt   = req_skew0;
          w_skewx_nxt   = req_skewX;
          w_grant_nxt   = 2'b00;
          w_timeout_nxt = 1'b0;
          w_tstate_nxt  = 1'b0;
          w_ph_nxt      = '0;
          w_to_nxt      = '0;
          w_state_nxt   = ST_CLEAR;
        end
      end

      // Minimum clear time is tracked by r_ph (saturating); r_to bounds a stuck latch.
      ST_CLEAR: begin
        w_to_nxt = r_to + 1'b1;
        if (r_ph != c_CLR_LAST) begin
          w_ph_nxt = r_ph + 1'b1;
        end
        if (r_ph == c_CLR_LAST && w_sync == 2'b00) begin
          w_ph_nxt = '0;
          if (r_mask == 2'b00) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_REPORT;
          end else begin
            w_tstate_nxt = 1'b1;
            w_state_nxt  = ST_ARM;
          end
        end else if (r_to == c_TO_LAST) begin
          w_grant_nxt   = w_sync;
          w_timeout_nxt = 1'b1;
          w_valid_nxt   = 1'b1;
          w_state_nxt   = ST_REPORT;
        end
      end

      ST_ARM: begin
        if (r_ph == c_ARM_LAST) begin
          w_ph_nxt    = '0;
          w_i0_nxt    = r_mask[0];
          w_i1_nxt    = r_mask[1];
          w_state_nxt = ST_FIRE;
        end else begin
          w_ph_nxt = r_ph + 1'b1;
        end
      end

      ST_FIRE: begin
        if (r_ph == c_PULSE_LAST) begin
          w_ph_nxt    = '0;
          w_to_nxt    = '0;
          w_state_nxt = ST_WAIT;
        end else begin
          w_ph_nxt = r_ph + 1'b1;
          w_i0_nxt = r_mask[0];
          w_i1_nxt = r_mask[1];
        end
      end

      ST_WAIT: begin
        w_to_nxt = r_to + 1'b1;
        if (w_sync != 2'b00) begin
          w_grant_nxt = w_sync;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_REPORT;
        end else if (r_to == c_TO_LAST) begin
          w_grant_nxt   = w_sync;
          w_timeout_nxt = 1'b1;
          w_valid_nxt   = 1'b1;
          w_state_nxt   = ST_REPORT;
        end
      end

      ST_REPORT: begin
        if (rsp_ready) begin
          w_valid_nxt  = 1'b0;
          w_tstate_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end

      default: begin
        w_tstate_nxt = 1'b0;
        w_valid_nxt  = 1'b0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign rsp_valid    = r_valid;
  assign rsp_grant    = r_grant;
  assign rsp_timeout  = r_timeout;
  assign i0           = r_i0;
  assign i1           = r_i1;
  assign Tstate       = r_tstate;
  assign Tpriority0_0 = r_skew0[0];
  assign Tpriority0_1 = r_skew0[1];
  assign TpriorityX_0 = r_skewx[0];
  assign TpriorityX_1 = r_skewx[1];

endmodule

`default_nettype wire

// File: tb/tb_vespa_priority_stepdown_driver.sv
// ============================================================================
// Module   : tb_vespa_priority_stepdown_driver
// Purpose  : Directed stimulus against a behavioural latch model, with a
//            queue-based response scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vespa_priority_stepdown_driver;

  logic       CELCLK = 1'b0;
  logic       CELRST = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_mask = 2'b00;
  logic [1:0] req_skew0 = 2'b00;
  logic [1:0] req_skewX = 2'b00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [1:0] rsp_grant;
  logic       rsp_timeout;
  logic       i0, i1;
  logic       o0 = 1'b0, o1 = 1'b0;
  logic       Tstate;
  logic       Tpriority0_0, Tpriority0_1, TpriorityX_0, TpriorityX_1;
  logic       busy;

  vespa_priority_stepdown_driver u_dut (
    .CELCLK       (CELCLK),
    .CELRST       (CELRST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mask     (req_mask),
    .req_skew0    (req_skew0),
    .req_skewX    (req_skewX),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_grant    (rsp_grant),
    .rsp_timeout  (rsp_timeout),
    .i0           (i0),
    .i1           (i1),
    .o0           (o0),
    .o1           (o1),
    .Tstate       (Tstate),
    .Tpriority0_0 (Tpriority0_0),
    .Tpriority0_1 (Tpriority0_1),
    .TpriorityX_0 (TpriorityX_0),
    .TpriorityX_1 (TpriorityX_1),
    .busy         (busy)
  );

  always #5 CELCLK = ~CELCLK;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n_i0 = 0, n_i1 = 0, n_ts = 0;
  int n_rsp = 0;
  logic [2:0] exp_q[$];

  // Latch model: a request sets its output two cycles after the pulse rises.
  logic en0 = 1'b1, en1 = 1'b1, stuck0 = 1'b0;
  logic d0 = 1'b0, d1 = 1'b0;

  logic       tp_watch = 1'b0;
  logic       tp_bad = 1'b0;
  logic [3:0] tp_exp = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge CELCLK) begin
    cyc <= cyc + 1;
    d0  <= i0;
    d1  <= i1;
    if (stuck0)       o0 <= 1'b1;
    else if (!Tstate) o0 <= 1'b0;
    else if (d0 && en0) o0 <= 1'b1;
    if (!Tstate)      o1 <= 1'b0;
    else if (d1 && en1) o1 <= 1'b1;
  end

  always @(negedge CELCLK) begin
    if (i0) n_i0++;
    if (i1) n_i1++;
    if (Tstate) n_ts++;
    if (tp_watch && {Tpriority0_1, Tpriority0_0, TpriorityX_1, TpriorityX_0} !== tp_exp)
      tp_bad = 1'b1;
  end

  // Scoreboard monitor: one pop per accepted response.
  always @(negedge CELCLK) begin
    logic [2:0] e;
    if (!CELRST && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_grant", {30'd0, rsp_grant}, {30'd0, e[2:1]});
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e[0]});
        n_rsp++;
      end
    end
  end

  task automatic do_req(input logic [1:0] m, input logic [1:0] s0, input logic [1:0] sx,
                        output int acc);
    int k;
    k = 0;
    repeat (4) @(negedge CELCLK);
    while (!req_ready && k < 100) begin
      @(negedge CELCLK);
      k++;
    end
    if (!req_ready) chk("req_ready_wait", 32'd0, 32'd1);
    req_mask  = m;
    req_skew0 = s0;
    req_skewX = sx;
    req_valid = 1'b1;
    @(posedge CELCLK);
    #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int acc, output int lat);
    int k;
    k = 0;
    @(negedge CELCLK);
    while (!rsp_valid && k < 200) begin
      @(negedge CELCLK);
      k++;
    end
    if (rsp_valid) lat = cyc - acc;
    else begin
      lat = -1;
      chk("rsp_valid_wait", 32'd0, 32'd1);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge CELCLK);
      k++;
    end
    chk("return_idle", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int acc, lat, s_i0, s_i1, s_ts, k;

    // Reset state
    repeat (3) @(posedge CELCLK);
    @(negedge CELCLK);
    chk("rst_ready_busy", {30'd0, req_ready, busy}, 32'b10);
    chk("rst_pulses_tstate", {29'd0, i0, i1, Tstate}, 32'b000);
    chk("rst_rsp", {28'd0, rsp_valid, rsp_grant, rsp_timeout}, 32'b0000);
    chk("rst_tprio", {28'd0, Tpriority0_1, Tpriority0_0, TpriorityX_1, TpriorityX_0}, 32'h0);
    @(posedge CELCLK);
    #1 CELRST = 1'b0;

    // mask=01, skew0=10, skewX=01: single grant on o0
    rsp_ready = 1'b1;
    s_i0 = n_i0; s_i1 = n_i1;
    exp_q.push_back({2'b01, 1'b0});
    tp_exp = 4'b1001;
    do_req(2'b01, 2'b10, 2'b01, acc);
    tp_watch = 1'b1;
    wait_rsp(acc, lat);
    chk("t1_latency", lat, 32'd8);
    wait_idle();
    tp_watch = 1'b0;
    chk("t1_tprio_stable", {31'd0, tp_bad}, 32'd0);
    chk("t1_i0_width", n_i0 - s_i0, 32'd2);
    chk("t1_i1_silent", n_i1 - s_i1, 32'd0);

    // mask=11, both latch; response back-pressured for 5 cycles
    rsp_ready = 1'b0;
    exp_q.push_back({2'b11, 1'b0});
    do_req(2'b11, 2'b00, 2'b11, acc);
    wait_rsp(acc, lat);
    chk("t2_latency", lat, 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge CELCLK);
      chk("t2_hold", {27'd0, rsp_valid, rsp_grant, Tstate, req_ready}, 32'b11110);
    end
    @(posedge CELCLK);
    #1 rsp_ready = 1'b1;
    @(negedge CELCLK);
    @(negedge CELCLK);
    chk("t2_after_accept", {29'd0, rsp_valid, Tstate, req_ready}, 32'b001);

    // mask=10, latch never answers: WAIT timeout
    en1 = 1'b0;
    s_i0 = n_i0; s_i1 = n_i1;
    exp_q.push_back({2'b00, 1'b1});
    do_req(2'b10, 2'b00, 2'b00, acc);
    wait_rsp(acc, lat);
    chk("t3_latency", lat, 32'd21);
    wait_idle();
    chk("t3_i1_width", n_i1 - s_i1, 32'd2);
    chk("t3_i0_silent", n_i0 - s_i0, 32'd0);
    en1 = 1'b1;

    // o0 stuck at request start, released 5 cycles after accept
    stuck0 = 1'b1;
    repeat (4) @(posedge CELCLK);
    exp_q.push_back({2'b01, 1'b0});
    do_req(2'b01, 2'b00, 2'b00, acc);
    repeat (5) @(posedge CELCLK);
    #1 stuck0 = 1'b0;
    wait_rsp(acc, lat);
    chk("t4_latency", cyc - acc, 32'd15);
    wait_idle();

    // o0 stuck forever: timeout from CLEAR, no pulses, Tstate never arms
    stuck0 = 1'b1;
    repeat (4) @(posedge CELCLK);
    s_i0 = n_i0; s_i1 = n_i1; s_ts = n_ts;
    exp_q.push_back({2'b01, 1'b1});
    do_req(2'b11, 2'b00, 2'b00, acc);
    wait_rsp(acc, lat);
    chk("t5_latency", lat, 32'd16);
    stuck0 = 1'b0;
    wait_idle();
    chk("t5_no_pulses", (n_i0 - s_i0) + (n_i1 - s_i1), 32'd0);
    chk("t5_tstate_low", n_ts - s_ts, 32'd0);

    // mask=00: clear-only pass
    s_i0 = n_i0; s_i1 = n_i1; s_ts = n_ts;
    exp_q.push_back({2'b00, 1'b0});
    do_req(2'b00, 2'b00, 2'b00, acc);
    wait_rsp(acc, lat);
    chk("t6_latency", lat, 32'd2);
    wait_idle();
    chk("t6_no_activity", (n_i0 - s_i0) + (n_i1 - s_i1) + (n_ts - s_ts), 32'd0);

    // Reset during FIRE
    do_req(2'b11, 2'b00, 2'b00, acc);
    k = 0;
    while (!i0 && k < 50) begin
      @(negedge CELCLK);
      k++;
    end
    chk("t7_fire_reached", {31'd0, i0}, 32'd1);
    CELRST = 1'b1;
    @(posedge CELCLK);
    #1;
    chk("t7_reset_outputs", {27'd0, i0, i1, Tstate, rsp_valid, req_ready}, 32'b00001);
    CELRST = 1'b0;
    repeat (6) @(negedge CELCLK);
    chk("t7_still_idle", {30'd0, busy, rsp_valid}, 32'b00);

    chk("responses_seen", n_rsp, 32'd6);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
